// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: DEPTH-entry circular buffer with a valid/ready handshake, flush and NOP bubble.
// Latency: 1 cycle from an accepted push into an empty buffer to out_valid. No bypass path.
// Backpressure: in_ready = (count < DEPTH) from the count register only, so no combinational path from out_ready.
//
// Ports:
//   CLK, RST      rising-edge clock; asynchronous active-high reset
//   flush         synchronous clear of every entry; dominates a same-cycle push and pop
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake; out_data = BUBBLE while empty
//   count         occupied entries
//   overflow_err  sticky; upstream dropped in_valid while refused (protocol violation)
module pipe_stage_elastic #(
    parameter int               WIDTH  = 64,
    parameter int               DEPTH  = 2,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow_err
);
    localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW       = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]   PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    // Upstream was refused last cycle and must keep in_valid asserted.
    logic          refused_q, refused_d;
    logic          overflow_q, overflow_d;

    logic push;
    logic pop;

    assign in_ready     = (count_q < CNT_FULL);
    assign out_valid    = (count_q != '0);
    assign out_data     = out_valid ? mem_q[rd_ptr_q] : BUBBLE;
    assign count        = count_q;
    assign overflow_err = overflow_q;

    always_comb begin
        push       = in_valid && in_ready && !flush;
        pop        = out_valid && out_ready && !flush;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        refused_d  = in_valid && !in_ready && !flush;
        overflow_d = overflow_q || (refused_q && !in_valid);

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            refused_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            refused_q  <= refused_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload storage needs no reset: out_data is masked by out_valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
module tb_pipe_stage_elastic;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fl   [2] = '{1'b0, 1'b0};
    logic       iv   [2] = '{1'b0, 1'b0};
    logic       ordy [2] = '{1'b0, 1'b0};
    logic [7:0] id   [2] = '{8'h00, 8'h00};
    logic       ir   [2];
    logic       ov   [2];
    logic [7:0] od   [2];
    logic [1:0] cnt  [2];
    logic       err  [2];

    int ncmp  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.WIDTH(8), .DEPTH(2), .BUBBLE(8'h00)) dut0 (
        .CLK(clk), .RST(rst), .flush(fl[0]),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .count(cnt[0]), .overflow_err(err[0])
    );

    pipe_stage_elastic #(.WIDTH(8), .DEPTH(3), .BUBBLE(8'hEE)) dut1 (
        .CLK(clk), .RST(rst), .flush(fl[1]),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .count(cnt[1]), .overflow_err(err[1])
    );

    function automatic int dep_of(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic logic [7:0] bub_of(input int i);
        return (i == 0) ? 8'h00 : 8'hEE;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a FIFO of accepted payloads per instance, plus the protocol-violation flag.
    logic [7:0] mq [2][$];
    bit         pend [2] = '{1'b0, 1'b0};
    bit         merr [2] = '{1'b0, 1'b0};

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            int sz;
            bit do_pop;
            bit do_push;
            if (rst) begin
                mq[i].delete();
                pend[i] = 1'b0;
                merr[i] = 1'b0;
            end else begin
                sz      = mq[i].size();
                do_pop  = (sz != 0) && ordy[i] && !fl[i];
                do_push = iv[i] && (sz < dep_of(i)) && !fl[i];
                if (pend[i] && !iv[i]) merr[i] = 1'b1;
                pend[i] = iv[i] && !(sz < dep_of(i)) && !fl[i];
                if (fl[i]) begin
                    mq[i].delete();
                end else begin
                    if (do_pop)  void'(mq[i].pop_front());
                    if (do_push) mq[i].push_back(id[i]);
                end
            end
        end
    end

    // Every cycle: DUT outputs against the model; log delivered payloads.
    logic [7:0] obs [2][$];
    int         maxc1 = 0;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int sz;
            sz = mq[i].size();
            chk($sformatf("d%0d.out_valid", i), 32'(ov[i]), 32'(sz != 0));
            chk($sformatf("d%0d.out_data", i), 32'(od[i]), 32'((sz != 0) ? mq[i][0] : bub_of(i)));
            chk($sformatf("d%0d.count", i), 32'(cnt[i]), 32'(sz));
            chk($sformatf("d%0d.in_ready", i), 32'(ir[i]), 32'(sz < dep_of(i)));
            chk($sformatf("d%0d.overflow_err", i), 32'(err[i]), 32'(merr[i]));
            if (!rst && ov[i] && ordy[i] && !fl[i]) obs[i].push_back(od[i]);
        end
        if (int'(cnt[1]) > maxc1) maxc1 = int'(cnt[1]);
    end

    // Called at posedge+1; holds in_valid/in_data until accepted (bounded).
    task automatic xfer(input int i, input logic [7:0] d);
        bit acc;
        int n;
        iv[i] = 1'b1;
        id[i] = d;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = ir[i] && !fl[i];
            @(posedge clk);
            #1;
            n++;
        end
        iv[i] = 1'b0;
        if (!acc) begin
            ncmp++;
            nfail++;
            $display("FAIL d%0d.xfer_timeout: got no acceptance, expected acceptance of %0h", i, d);
        end
    endtask

    logic [7:0] expq [$];

    task automatic chk_seq(input int i, input string nm);
        chk({nm, ".len"}, 32'(obs[i].size()), 32'(expq.size()));
        for (int k = 0; k < expq.size() && k < obs[i].size(); k++)
            chk($sformatf("%s[%0d]", nm, k), 32'(obs[i][k]), 32'(expq[k]));
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    bit stop_rand;

    initial begin
        cycles(2);
        rst = 1'b0;

        // Reset state
        chk("rst.out_valid", 32'(ov[0]), 32'd0);
        chk("rst.out_data", 32'(od[0]), 32'h00);
        chk("rst.count", 32'(cnt[0]), 32'd0);
        chk("rst.in_ready", 32'(ir[0]), 32'd1);
        chk("rst.bubble_d3", 32'(od[1]), 32'hEE);
        chk("rst.overflow_err", 32'(err[0]), 32'd0);

        // Single payload through an empty buffer
        ordy[0] = 1'b1;
        xfer(0, 8'hA5);
        @(negedge clk);
        chk("single.out_valid", 32'(ov[0]), 32'd1);
        chk("single.out_data", 32'(od[0]), 32'hA5);
        @(negedge clk);
        chk("single.count_after", 32'(cnt[0]), 32'd0);
        cycles(1);

        // Back-to-back stream, DEPTH=2
        obs[0].delete();
        for (int k = 1; k <= 8; k++) begin
            xfer(0, 8'(k));
            chk($sformatf("stream.count%0d", k), 32'(cnt[0]), 32'd1);
            chk($sformatf("stream.in_ready%0d", k), 32'(ir[0]), 32'd1);
        end
        cycles(3);
        expq = '{8'h1, 8'h2, 8'h3, 8'h4, 8'h5, 8'h6, 8'h7, 8'h8};
        chk_seq(0, "stream.seq");

        // Stall fill then release
        obs[0].delete();
        ordy[0] = 1'b0;
        xfer(0, 8'h10);
        chk("fill.count1", 32'(cnt[0]), 32'd1);
        xfer(0, 8'h11);
        chk("fill.count2", 32'(cnt[0]), 32'd2);
        chk("fill.in_ready", 32'(ir[0]), 32'd0);
        fork
            xfer(0, 8'h12);
            begin
                cycles(3);
                ordy[0] = 1'b1;
            end
        join
        cycles(4);
        expq = '{8'h10, 8'h11, 8'h12};
        chk_seq(0, "fill.seq");

        // Wrap with DEPTH=3 under random stalls
        obs[1].delete();
        maxc1 = 0;
        stop_rand = 1'b0;
        fork
            begin
                for (int k = 0; k < 10; k++) xfer(1, 8'h20 + 8'(k));
                stop_rand = 1'b1;
            end
            while (!stop_rand) begin
                ordy[1] = 1'($urandom_range(0, 1));
                cycles(1);
            end
        join
        ordy[1] = 1'b1;
        cycles(6);
        expq.delete();
        for (int k = 0; k < 10; k++) expq.push_back(8'h20 + 8'(k));
        chk_seq(1, "wrap.seq");
        chk("wrap.max_count_le3", 32'(maxc1 <= 3), 32'd1);
        chk("wrap.empty_bubble", 32'(od[1]), 32'hEE);

        // Flush colliding with push and pop
        obs[0].delete();
        ordy[0] = 1'b0;
        xfer(0, 8'h40);
        xfer(0, 8'h41);
        chk("flush.pre_count", 32'(cnt[0]), 32'd2);
        fl[0] = 1'b1;
        iv[0] = 1'b1;
        id[0] = 8'h55;
        ordy[0] = 1'b1;
        cycles(1);
        fl[0] = 1'b0;
        iv[0] = 1'b0;
        chk("flush.count", 32'(cnt[0]), 32'd0);
        chk("flush.out_valid", 32'(ov[0]), 32'd0);
        chk("flush.out_data", 32'(od[0]), 32'h00);
        chk("flush.in_ready", 32'(ir[0]), 32'd1);
        cycles(2);
        chk("flush.nothing_delivered", 32'(obs[0].size()), 32'd0);

        // Protocol violation: drop in_valid while refused
        ordy[0] = 1'b0;
        xfer(0, 8'h30);
        xfer(0, 8'h31);
        iv[0] = 1'b1;
        id[0] = 8'h77;
        cycles(1);
        iv[0] = 1'b0;
        cycles(1);
        chk("ovf.sticky_set", 32'(err[0]), 32'd1);
        chk("ovf.count", 32'(cnt[0]), 32'd2);

        // Async reset between edges with count=2
        #3;
        rst = 1'b1;
        #1;
        chk("arst.count", 32'(cnt[0]), 32'd0);
        chk("arst.out_valid", 32'(ov[0]), 32'd0);
        chk("arst.out_data", 32'(od[0]), 32'h00);
        chk("arst.in_ready", 32'(ir[0]), 32'd1);
        chk("arst.overflow_err", 32'(err[0]), 32'd0);
        cycles(1);
        rst = 1'b0;
        cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised elastic pipeline register; successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Replaces the single-entry EN/flush latch with a DEPTH-entry buffer using a valid/ready handshake.
- A downstream stall no longer has to propagate combinationally upstream in the same cycle.
- Payload is an opaque WIDTH-bit bundle (instr, npc, control bits packed by the instantiating stage).
- Supports synchronous flush and drives a NOP bubble when empty.

Parameters:
WIDTH, 64, payload width in bits (>=1)
DEPTH, 2, number of buffer entries (>=1; need not be a power of two)
BUBBLE, 0, value driven on out_data while out_valid=0 (0 = MIPS sll $0,$0,0 NOP)

Ports:
CLK  input  1  clock, rising-edge
RST  input  1  asynchronous active-high reset
flush  input  1  synchronous clear of all entries (branch mispredict / jump squash)
in_valid  input  1  upstream presents payload
in_ready  output  1  buffer can accept; registered, no combinational path from out_ready
in_data  input  WIDTH  upstream payload
out_valid  output  1  head entry valid
out_ready  input  1  downstream consumes head this cycle
out_data  output  WIDTH  head payload, or BUBBLE when empty
count  output  $clog2(DEPTH+1)  number of occupied entries
overflow_err  output  1  sticky; set if in_valid&&!in_ready&&!flush ever seen with pending data lost (debug only)

Behaviour:
- Storage: circular array of DEPTH entries; rd_ptr, wr_ptr in [0,DEPTH-1]; count register.
- Reset (RST=1, async): rd_ptr=wr_ptr=0, count=0, out_valid=0, out_data=BUBBLE, in_ready=1, overflow_err=0. Array contents are don't-care.
- push = in_valid && in_ready && !flush.
- pop = out_valid && out_ready && !flush.
- Push: mem[wr_ptr]<=in_data; wr_ptr increments and wraps to 0 after DEPTH-1.
- Pop: rd_ptr increments with the same wrap rule.
- count_next = count + push - pop. Push and pop in the same cycle leave count unchanged, which is legal at any occupancy where both are enabled.
- in_ready = (count < DEPTH). It is derived from the count register only, so a full buffer refuses pushes even when out_ready=1 that cycle.
- out_valid = (count != 0).
- out_data = mem[rd_ptr] when out_valid, else BUBBLE.
- Latency: data pushed at edge k appears on out_data/out_valid after edge k (1 cycle) when the buffer was empty. There is no bypass path.
- Throughput: 1 payload/cycle sustained when DEPTH>=2.
- With DEPTH=1, throughput is 1 payload per 2 cycles, because in_ready stays low while the single entry is held.
- Flush: at the edge where flush=1, count<=0, rd_ptr<=wr_ptr<=0, and out_valid is 0 the next cycle. Flush dominates a simultaneous push and pop; neither takes effect. in_ready is 1 the cycle after flush.
- Stall (out_ready=0): head and all entries hold. out_data is stable while out_valid=1 && out_ready=0 (handshake stability rule).
- Upstream rule: once asserted, in_valid/in_data must hold until accepted or flushed.
- overflow_err: set when in_valid=1, in_ready=0 and in_valid deasserts next cycle without acceptance (protocol violation). Cleared only by RST.
- Reset mid-operation: all state is cleared immediately; there is no partial drain.

Test Plan:
- Reset then idle: RST pulse -> count=0, out_valid=0, out_data=0, in_ready=1. Drive in_valid=1, data=0xA5 with out_ready=1 -> out_valid=1, out_data=0xA5 next cycle; then empty (count=0) one cycle later.
- Back-to-back stream, DEPTH=2: push 0x1..0x8 on consecutive cycles with out_ready=1 -> outputs 0x1..0x8 on consecutive cycles, in_ready stays 1, count stays 1.
- Stall fill, DEPTH=2: out_ready=0, push 0x10, 0x11, 0x12 -> count=2 and in_ready=0 after the second push; 0x12 is held upstream. Release out_ready -> order 0x10, 0x11, 0x12 with no loss or duplication.
- Wrap with DEPTH=3: 10 pushes with random out_ready stalls -> pointers wrap 2->0, output order matches input order, count never exceeds 3.
- Flush collision: count=2, assert flush with in_valid=1 (0x55) and out_ready=1 -> next cycle count=0, out_valid=0, out_data=BUBBLE, 0x55 not stored, in_ready=1.
- Async reset mid-stream: assert RST between edges while count=2 -> outputs return to reset values immediately, without waiting for CLK.
